// File: rtl/scroll_pkg.sv
// Shared definitions for the obstacle scroll sequencer: FSM state encoding,
// obstacle LFSR seed and tap mask, score width and a saturating increment.
package scroll_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_OVER = 2'd3
  } scrollStateT;

  // x^8 + x^6 + x^5 + x^4 + 1
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  localparam int SCORE_W = 16;

  function automatic logic [SCORE_W-1:0] satInc(input logic [SCORE_W-1:0] v);
    return (&v) ? v : v + SCORE_W'(1);
  endfunction

endpackage

// File: rtl/segment_scroll_ctrl_if.sv
// Game-side and shift-register-side signals of the scroll sequencer.
// Optional macro SCROLL_PAUSE_EN adds the Pause input.
interface segment_scroll_ctrl_if;
  import scroll_pkg::*;

  logic                Start;
  logic                Collide;
`ifdef SCROLL_PAUSE_EN
  logic                Pause;
`endif
  logic                BitIn;
  logic                Shift;
  logic                SrRst;
  logic [5:0]          RstValue;
  logic                Running;
  logic                GameOver;
  logic [SCORE_W-1:0]  Score;

  modport master (
`ifdef SCROLL_PAUSE_EN
    output Pause,
`endif
    output Start, Collide,
    input  BitIn, Shift, SrRst, RstValue, Running, GameOver, Score
  );

  modport slave (
`ifdef SCROLL_PAUSE_EN
    input  Pause,
`endif
    input  Start, Collide,
    output BitIn, Shift, SrRst, RstValue, Running, GameOver, Score
  );

endinterface

// File: rtl/obstacle_lfsr.sv
// 8-bit Fibonacci LFSR feeding the obstacle stream; steps only when Advance is high.
module obstacle_lfsr
  import scroll_pkg::*;
(
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Advance,
  output logic [7:0] Lfsr
);

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      Lfsr <= LFSR_SEED;
    end else if (Advance) begin
      Lfsr <= {^(Lfsr & LFSR_TAPS), Lfsr[7:1]};
    end
  end

endmodule

// File: rtl/segment_scroll_ctrl.sv
// Scroll sequencer for the 6-bit obstacle shift register: tick timing, obstacle
// stream with minimum gap, speed-up, score and game-over. Optional macro: SCROLL_PAUSE_EN.
//
// state  | meaning
// IDLE   | register held at SEED_PATTERN, waiting for Start
// LOAD   | one cycle: clear score, restore period, restart counters
// RUN    | scrolling; Collide ends the game
// OVER   | display frozen, no shifts; Start begins a new game
module segment_scroll_ctrl
  import scroll_pkg::*;
#(
  parameter int         INIT_PERIOD   = 24,
  parameter int         MIN_PERIOD    = 6,
  parameter int         SPEED_STEP    = 2,
  parameter int         SPEEDUP_EVERY = 16,
  parameter int         MIN_GAP       = 2,
  parameter logic [5:0] SEED_PATTERN  = 6'b000000
) (
  input logic                  Clk,
  input logic                  Rst,
  segment_scroll_ctrl_if.slave bus
);

  localparam int PW = $clog2(INIT_PERIOD + 1);
  localparam int GW = (MIN_GAP < 1) ? 1 : $clog2(MIN_GAP + 1);
  localparam logic [PW-1:0] ONE = PW'(1);
  localparam logic [PW-1:0] TWO = PW'(2);

  scrollStateT        stateQ, stateD;
  logic [PW-1:0]      cntQ, cntD;
  logic [PW-1:0]      periodQ, periodD, fasterPeriod;
  logic [4:0]         stepQ, stepD;
  logic [GW-1:0]      gapQ, gapD;
  logic               gapOk;
  logic               pause;
  logic               runAct;
  logic               shiftDone;
  logic               bitStep;
  logic [7:0]         lfsr;
  logic               unusedLfsrHi;

  logic               bitInQ, bitInD;
  logic               shiftQ, shiftD;
  logic               srRstQ, srRstD;
  logic               runningQ, runningD;
  logic               gameOverQ, gameOverD;
  logic [SCORE_W-1:0] scoreQ, scoreD;

`ifdef SCROLL_PAUSE_EN
  assign pause = bus.Pause;
`else
  assign pause = 1'b0;
`endif

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      stateQ <= S_IDLE;
    end else begin
      stateQ <= stateD;
    end
  end

  always_comb begin
    stateD = stateQ;
    case (stateQ)
      S_IDLE:  if (bus.Start)   stateD = S_LOAD;
      S_LOAD:                   stateD = S_RUN;
      S_RUN:   if (bus.Collide) stateD = S_OVER;
      S_OVER:  if (bus.Start)   stateD = S_LOAD;
      default:                  stateD = S_IDLE;
    endcase
  end

  // Collision beats the scroll step that would otherwise complete this cycle.
  always_comb begin
    runAct    = (stateQ == S_RUN) && !bus.Collide && !pause;
    shiftDone = (stateQ == S_RUN) && shiftQ && !bus.Collide;
    gapOk     = (int'(gapQ) >= MIN_GAP);

    if (int'(periodQ) >= MIN_PERIOD + SPEED_STEP) begin
      fasterPeriod = periodQ - PW'(SPEED_STEP);
    end else begin
      fasterPeriod = PW'(MIN_PERIOD);
    end

    cntD    = cntQ;
    periodD = periodQ;
    stepD   = stepQ;
    if (stateQ == S_LOAD) begin
      cntD    = '0;
      periodD = PW'(INIT_PERIOD);
      stepD   = '0;
    end else begin
      // Period changes only at the wrap edge, so the running count never straddles two periods.
      if (shiftDone) begin
        if (stepQ == 5'(SPEEDUP_EVERY - 1)) begin
          stepD   = '0;
          periodD = fasterPeriod;
        end else begin
          stepD = stepQ + 5'd1;
        end
      end
      if (runAct) begin
        cntD = (cntQ >= periodQ - ONE) ? '0 : cntQ + ONE;
      end
    end

    bitStep = runAct && (cntD == periodD - TWO);

    gapD = gapQ;
    if (stateQ == S_LOAD) begin
      gapD = GW'(MIN_GAP);
    end else if (bitStep) begin
      if (lfsr[0] && gapOk) begin
        gapD = '0;
      end else if (!gapOk) begin
        gapD = gapQ + GW'(1);
      end
    end
  end

  always_comb begin
    srRstD    = (stateD == S_RUN) || (stateD == S_OVER);
    runningD  = (stateD == S_RUN);
    gameOverD = (stateD == S_OVER);
    shiftD    = runAct && (cntD == periodD - ONE);

    bitInD = bitInQ;
    if (stateQ == S_LOAD) begin
      bitInD = 1'b0;
    end else if (bitStep) begin
      bitInD = lfsr[0] && gapOk;
    end

    scoreD = scoreQ;
    if (stateQ == S_LOAD) begin
      scoreD = '0;
    end else if (shiftDone) begin
      scoreD = satInc(scoreQ);
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      cntQ      <= '0;
      periodQ   <= PW'(INIT_PERIOD);
      stepQ     <= '0;
      gapQ      <= GW'(MIN_GAP);
      bitInQ    <= 1'b0;
      shiftQ    <= 1'b0;
      srRstQ    <= 1'b0;
      runningQ  <= 1'b0;
      gameOverQ <= 1'b0;
      scoreQ    <= '0;
    end else begin
      cntQ      <= cntD;
      periodQ   <= periodD;
      stepQ     <= stepD;
      gapQ      <= gapD;
      bitInQ    <= bitInD;
      shiftQ    <= shiftD;
      srRstQ    <= srRstD;
      runningQ  <= runningD;
      gameOverQ <= gameOverD;
      scoreQ    <= scoreD;
    end
  end

  obstacle_lfsr uLfsr (
    .Clk     (Clk),
    .Rst     (Rst),
    .Advance (bitStep),
    .Lfsr    (lfsr)
  );

  assign unusedLfsrHi = ^lfsr[7:1];

  assign bus.BitIn    = bitInQ;
  assign bus.Shift    = shiftQ;
  assign bus.SrRst    = srRstQ;
  assign bus.RstValue = SEED_PATTERN;
  assign bus.Running  = runningQ;
  assign bus.GameOver = gameOverQ;
  assign bus.Score    = scoreQ;

endmodule

// File: tb/tb_segment_scroll_ctrl.sv
// Scoreboard bench for segment_scroll_ctrl: two instances (fixed period, fast speed-up);
// expected Shift events are queued at stimulus time and checked by a monitor.
module tb_segment_scroll_ctrl;

  typedef struct {
    int          cyc;
    logic        bitIn;
    logic [15:0] score;
  } shiftEvT;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;

  shiftEvT qA[$];
  shiftEvT qB[$];
  shiftEvT evA, evB;

  // lfsr[0] from seed A5: 1,0,1,0,0,1,0,1,0,1,1,0 ; after the MIN_GAP=2 filter:
  logic bitTab [0:11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                          1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  // Periods 5,5,4,4,3,3,3 starting with RUN in cycle 12
  int cycB [0:6] = '{16, 21, 25, 29, 32, 35, 38};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  segment_scroll_ctrl_if busA ();
  segment_scroll_ctrl_if busB ();

  segment_scroll_ctrl #(
    .INIT_PERIOD(4), .MIN_PERIOD(3), .SPEED_STEP(1), .SPEEDUP_EVERY(16),
    .MIN_GAP(2), .SEED_PATTERN(6'b000000)
  ) dutA (
    .Clk(clk), .Rst(rst), .bus(busA)
  );

  segment_scroll_ctrl #(
    .INIT_PERIOD(5), .MIN_PERIOD(3), .SPEED_STEP(1), .SPEEDUP_EVERY(2),
    .MIN_GAP(2), .SEED_PATTERN(6'b000000)
  ) dutB (
    .Clk(clk), .Rst(rst), .bus(busB)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic shiftEvT mkEv(input int c, input logic b, input int s);
    shiftEvT e;
    e.cyc   = c;
    e.bitIn = b;
    e.score = 16'(s);
    return e;
  endfunction

  task automatic goTo(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkIdleA(input string tag);
    check({tag, "_A_SrRst"},    32'(busA.SrRst), 0);
    check({tag, "_A_Shift"},    32'(busA.Shift), 0);
    check({tag, "_A_BitIn"},    32'(busA.BitIn), 0);
    check({tag, "_A_Score"},    32'(busA.Score), 0);
    check({tag, "_A_Running"},  32'(busA.Running), 0);
    check({tag, "_A_GameOver"}, 32'(busA.GameOver), 0);
  endtask

  always @(negedge clk) begin
    if (busA.Shift === 1'b1) begin
      if (qA.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL shiftA_unexpected: Shift seen at cycle %0d, none expected", cyc);
      end else begin
        evA = qA.pop_front();
        check("shiftA_cycle", 32'(cyc), 32'(evA.cyc));
        check("shiftA_bitin", 32'(busA.BitIn), 32'(evA.bitIn));
        check("shiftA_score", 32'(busA.Score), 32'(evA.score));
      end
    end
    if (busB.Shift === 1'b1) begin
      if (qB.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL shiftB_unexpected: Shift seen at cycle %0d, none expected", cyc);
      end else begin
        evB = qB.pop_front();
        check("shiftB_cycle", 32'(cyc), 32'(evB.cyc));
        check("shiftB_bitin", 32'(busB.BitIn), 32'(evB.bitIn));
        check("shiftB_score", 32'(busB.Score), 32'(evB.score));
      end
    end
  end

  initial begin
    busA.Start = 1'b0; busA.Collide = 1'b0;
    busB.Start = 1'b0; busB.Collide = 1'b0;
`ifdef SCROLL_PAUSE_EN
    busA.Pause = 1'b0; busB.Pause = 1'b0;
`endif
    rst = 1'b0;
    goTo(2);
    rst = 1'b1;

    // reset state
    checkIdleA("rst");
    check("rst_A_RstValue", 32'(busA.RstValue), 0);
    check("rst_B_SrRst",    32'(busB.SrRst), 0);
    check("rst_B_Score",    32'(busB.Score), 0);
    check("rst_B_RstValue", 32'(busB.RstValue), 0);
    goTo(9);
    checkIdleA("preStart");

    // start both games in cycle 10
    goTo(10);
    busA.Start = 1'b1;
    busB.Start = 1'b1;
    for (int k = 0; k < 12; k++) qA.push_back(mkEv(15 + 4 * k, bitTab[k], k));
    for (int k = 0; k < 7; k++)  qB.push_back(mkEv(cycB[k], bitTab[k], k));
    goTo(11);
    busA.Start = 1'b0;
    busB.Start = 1'b0;
    check("load_A_SrRst",   32'(busA.SrRst), 0);
    check("load_A_Running", 32'(busA.Running), 0);
    check("load_B_SrRst",   32'(busB.SrRst), 0);
    goTo(12);
    check("run_A_Running", 32'(busA.Running), 1);
    check("run_A_SrRst",   32'(busA.SrRst), 1);
    check("run_B_Running", 32'(busB.Running), 1);
    goTo(24);
    check("score3_A", 32'(busA.Score), 3);
    goTo(30);
    check("score4_B", 32'(busB.Score), 4);

    // stop B at the first count of a period
    goTo(39);
    busB.Collide = 1'b1;
    goTo(40);
    busB.Collide = 1'b0;
    check("over_B_GameOver", 32'(busB.GameOver), 1);
    check("over_B_Running",  32'(busB.Running), 0);
    goTo(41);
    check("over_B_Score", 32'(busB.Score), 7);

    // collide A in the cycle that would launch its 13th Shift
    goTo(62);
    busA.Collide = 1'b1;
    goTo(63);
    busA.Collide = 1'b0;
    check("hit_A_GameOver", 32'(busA.GameOver), 1);
    check("hit_A_Running",  32'(busA.Running), 0);
    check("hit_A_Score",    32'(busA.Score), 12);
    goTo(70);
    check("frozen_A_Score", 32'(busA.Score), 12);
    check("frozen_A_SrRst", 32'(busA.SrRst), 1);

    // restart from OVER with Start held across LOAD into RUN
    goTo(80);
    busA.Start = 1'b1;
    goTo(81);
    check("reload_A_SrRst",    32'(busA.SrRst), 0);
    check("reload_A_GameOver", 32'(busA.GameOver), 0);
    goTo(82);
    check("restart_A_Running", 32'(busA.Running), 1);
    check("restart_A_Score",   32'(busA.Score), 0);
    goTo(84);
    check("held_A_Running", 32'(busA.Running), 1);
    check("held_A_SrRst",   32'(busA.SrRst), 1);

    // reset at Cnt == Period-2, the cycle before a Shift pulse
    rst = 1'b0;
    goTo(85);
    rst = 1'b1;
    busA.Start = 1'b0;
    checkIdleA("midRst");
    check("midRst_B_GameOver", 32'(busB.GameOver), 0);

    // LFSR reseeded by reset
    goTo(90);
    busA.Start = 1'b1;
    qA.push_back(mkEv(95, 1'b1, 0));
    qA.push_back(mkEv(99, 1'b0, 1));
    goTo(91);
    busA.Start = 1'b0;
    goTo(101);
    busA.Collide = 1'b1;
    goTo(102);
    busA.Collide = 1'b0;
    check("end_A_GameOver", 32'(busA.GameOver), 1);
    check("end_A_Score",    32'(busA.Score), 2);

    goTo(110);
    check("pending_A", 32'(qA.size()), 0);
    check("pending_B", 32'(qB.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
